// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: duty-register owner and time-shared PWM engine for four RGB LEDs.
// Buttons edit the duty of the selected LED/colour, step the LED select and step
// the colour select. Switches gate each LED. One PWM counter serves all 12
// channels. Shadow duties reload only at the period boundary.
// Optional feature: define RGB_PWM_DEBOUNCE_EN to insert a per-button debouncer
// (IDLE_LOW / CHECK / IDLE_HIGH) between the synchroniser and the edge detector.
// Without it the synchronised level feeds the edge detector directly.

package rgb_pwm_pkg;
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_led_t;
endpackage

module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS        = 8,
    parameter int PRESCALE        = 400,
    parameter int STEP            = 16,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [3:0]          buttons,
    input  logic [3:0]          switches,
    output logic [3:0]          green_leds,
    output rgb_led_t [3:0]      rgb_leds
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX   = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DUTY_ZERO  = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS:0]   STEP_W     = (PWM_BITS+1)'(STEP);
    localparam int                  PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        COL_R = 2'd0,
        COL_G = 2'd1,
        COL_B = 2'd2
    } col_e;

    if (PRESCALE < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("rgb_pwm_ctrl: PRESCALE and DEBOUNCE_CYCLES must be >= 1");
    end

    // One-hot encode an LED index for the green select indicators.
    function automatic logic [3:0] led_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0001;
        endcase
        return oh;
    endfunction

    logic [3:0] btn_meta_r, btn_sync_r;
    logic [3:0] sw_meta_r, sw_sync_r;
    logic [3:0] level_s;
    logic [3:0] level_d_r;
    logic [3:0] press_r;

    // Two-flop synchronisers for the asynchronous buttons and switches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_meta_r <= 4'b0000;
            btn_sync_r <= 4'b0000;
            sw_meta_r  <= 4'b0000;
            sw_sync_r  <= 4'b0000;
        end else begin
            btn_meta_r <= buttons;
            btn_sync_r <= btn_meta_r;
            sw_meta_r  <= switches;
            sw_sync_r  <= sw_meta_r;
        end
    end

`ifdef RGB_PWM_DEBOUNCE_EN
    typedef enum logic [1:0] {
        DB_IDLE_LOW  = 2'd0,
        DB_CHECK     = 2'd1,
        DB_IDLE_HIGH = 2'd2
    } db_state_e;

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    db_state_e       db_state_r     [4];
    db_state_e       db_state_nxt_s [4];
    logic [DB_W-1:0] db_cnt_r       [4];
    logic [DB_W-1:0] db_cnt_nxt_s   [4];
    logic [3:0]      db_level_r;
    logic [3:0]      db_level_nxt_s;

    // Debouncer next state: a new level is accepted only after an unbroken run of equal samples.
    always_comb begin
        db_level_nxt_s = db_level_r;
        for (int i = 0; i < 4; i++) begin
            db_state_nxt_s[i] = db_state_r[i];
            db_cnt_nxt_s[i]   = db_cnt_r[i];
            case (db_state_r[i])
                DB_IDLE_LOW: begin
                    if (btn_sync_r[i]) begin
                        db_state_nxt_s[i] = DB_CHECK;
                        db_cnt_nxt_s[i]   = DB_W'(1);
                    end else begin
                        db_cnt_nxt_s[i]   = DB_W'(0);
                    end
                end
                DB_IDLE_HIGH: begin
                    if (!btn_sync_r[i]) begin
                        db_state_nxt_s[i] = DB_CHECK;
                        db_cnt_nxt_s[i]   = DB_W'(1);
                    end else begin
                        db_cnt_nxt_s[i]   = DB_W'(0);
                    end
                end
                DB_CHECK: begin
                    if (btn_sync_r[i] == db_level_r[i]) begin
                        // Candidate level vanished: fall back to the accepted level.
                        db_state_nxt_s[i] = db_level_r[i] ? DB_IDLE_HIGH : DB_IDLE_LOW;
                        db_cnt_nxt_s[i]   = DB_W'(0);
                    end else if (db_cnt_r[i] >= DB_LAST) begin
                        db_level_nxt_s[i] = btn_sync_r[i];
                        db_state_nxt_s[i] = btn_sync_r[i] ? DB_IDLE_HIGH : DB_IDLE_LOW;
                        db_cnt_nxt_s[i]   = DB_W'(0);
                    end else begin
                        db_cnt_nxt_s[i]   = db_cnt_r[i] + DB_W'(1);
                    end
                end
                default: begin
                    db_state_nxt_s[i] = DB_IDLE_LOW;
                    db_cnt_nxt_s[i]   = DB_W'(0);
                    db_level_nxt_s[i] = 1'b0;
                end
            endcase
        end
    end

    // Debouncer state, counter and accepted-level registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                db_state_r[i] <= DB_IDLE_LOW;
                db_cnt_r[i]   <= DB_W'(0);
            end
            db_level_r <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                db_state_r[i] <= db_state_nxt_s[i];
                db_cnt_r[i]   <= db_cnt_nxt_s[i];
            end
            db_level_r <= db_level_nxt_s;
        end
    end

    assign level_s = db_level_r;
`else
    assign level_s = btn_sync_r;
`endif

    // Rising-edge detect: one registered pulse per accepted press, however long it is held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_d_r <= 4'b0000;
            press_r   <= 4'b0000;
        end else begin
            level_d_r <= level_s;
            press_r   <= level_s & ~level_d_r;
        end
    end

    logic [PWM_BITS-1:0] duty_r   [12];
    logic [PWM_BITS-1:0] shadow_r [12];
    logic [1:0]          sel_led_r, sel_led_nxt_s;
    col_e                sel_col_r, sel_col_nxt_s;
    logic [3:0]          sel_idx_s;
    logic [PWM_BITS-1:0] cur_duty_s, edit_val_s;
    logic [PWM_BITS:0]   inc_sum_s;
    logic                edit_en_s;

    // Edit datapath: saturating inc/dec on the currently selected channel, select stepping.
    always_comb begin
        sel_idx_s  = ({2'b00, sel_led_r} * 4'd3) + {2'b00, sel_col_r};
        cur_duty_s = duty_r[sel_idx_s];
        inc_sum_s  = {1'b0, cur_duty_s} + STEP_W;
        edit_en_s  = press_r[0] ^ press_r[1];
        if (press_r[0] && !press_r[1]) begin
            edit_val_s = (inc_sum_s > {1'b0, DUTY_MAX}) ? DUTY_MAX : inc_sum_s[PWM_BITS-1:0];
        end else if (press_r[1] && !press_r[0]) begin
            edit_val_s = ({1'b0, cur_duty_s} < STEP_W) ? DUTY_ZERO
                                                       : (cur_duty_s - STEP_W[PWM_BITS-1:0]);
        end else begin
            edit_val_s = cur_duty_s;
        end
        if (press_r[2]) begin
            sel_led_nxt_s = sel_led_r + 2'd1;
        end else begin
            sel_led_nxt_s = sel_led_r;
        end
        sel_col_nxt_s = sel_col_r;
        if (press_r[3]) begin
            case (sel_col_r)
                COL_R:   sel_col_nxt_s = COL_G;
                COL_G:   sel_col_nxt_s = COL_B;
                COL_B:   sel_col_nxt_s = COL_R;
                default: sel_col_nxt_s = COL_R;
            endcase
        end else begin
            sel_col_nxt_s = sel_col_r;
        end
    end

    // Duty registers and selection state; an edit always lands on the pre-step selection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 12; i++) begin
                duty_r[i] <= DUTY_ZERO;
            end
            sel_led_r <= 2'd0;
            sel_col_r <= COL_R;
        end else begin
            if (edit_en_s) begin
                duty_r[sel_idx_s] <= edit_val_s;
            end
            sel_led_r <= sel_led_nxt_s;
            sel_col_r <= sel_col_nxt_s;
        end
    end

    logic [PRESC_W-1:0]  presc_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic                tick_s;
    logic                boundary_s;

    assign tick_s     = (presc_r == PRESC_LAST);
    assign boundary_s = tick_s && (pwm_cnt_r == DUTY_MAX);

    // Prescaler and shared PWM counter; shadows reload only when the counter wraps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_r   <= {PRESC_W{1'b0}};
            pwm_cnt_r <= DUTY_ZERO;
            for (int i = 0; i < 12; i++) begin
                shadow_r[i] <= DUTY_ZERO;
            end
        end else begin
            if (tick_s) begin
                presc_r   <= {PRESC_W{1'b0}};
                pwm_cnt_r <= pwm_cnt_r + {{(PWM_BITS-1){1'b0}}, 1'b1};
            end else begin
                presc_r   <= presc_r + {{(PRESC_W-1){1'b0}}, 1'b1};
            end
            if (boundary_s) begin
                for (int i = 0; i < 12; i++) begin
                    shadow_r[i] <= duty_r[i];
                end
            end
        end
    end

    rgb_led_t [3:0] rgb_nxt_s;
    rgb_led_t [3:0] rgb_r;
    logic [3:0]     green_r;

    // PWM compare per channel, gated by the synchronised LED enable switch.
    always_comb begin
        rgb_nxt_s = '{default: 1'b0};
        for (int n = 0; n < 4; n++) begin
            rgb_nxt_s[n].r = sw_sync_r[n] && (pwm_cnt_r < shadow_r[n*3 + 0]);
            rgb_nxt_s[n].g = sw_sync_r[n] && (pwm_cnt_r < shadow_r[n*3 + 1]);
            rgb_nxt_s[n].b = sw_sync_r[n] && (pwm_cnt_r < shadow_r[n*3 + 2]);
        end
    end

    // Registered LED outputs; reset drives every PWM output low on the next edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_r   <= '{default: 1'b0};
            green_r <= 4'b0001;
        end else begin
            rgb_r   <= rgb_nxt_s;
            green_r <= led_onehot(sel_led_nxt_s);
        end
    end

    assign rgb_leds   = rgb_r;
    assign green_leds = green_r;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Scoreboard bench for rgb_pwm_ctrl (PWM_BITS=4, PRESCALE=1, STEP=4).
// Stimulus pushes the expected per-channel on-counts over a window plus the
// expected green select; the monitor samples the window and compares.
module tb_rgb_pwm_ctrl;
    import rgb_pwm_pkg::*;

`ifdef RGB_PWM_DEBOUNCE_EN
    localparam int HOLD = 20;
`else
    localparam int HOLD = 4;
`endif

    logic           clk = 1'b0;
    logic           rst_i;
    logic [3:0]     buttons;
    logic [3:0]     switches;
    logic [3:0]     green_leds;
    rgb_led_t [3:0] rgb_leds;

    always #5 clk = ~clk;

    rgb_pwm_ctrl #(
        .PWM_BITS        (4),
        .PRESCALE        (1),
        .STEP            (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .buttons    (buttons),
        .switches   (switches),
        .green_leds (green_leds),
        .rgb_leds   (rgb_leds)
    );

    typedef struct {
        string       name;
        int          len;
        bit          chk_cnt;
        logic [59:0] cnt;
        logic [3:0]  green;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   issued   = 0;
    int   done_cnt = 0;
    bit   mon_go   = 1'b0;

    // Expected on-count vector: channel k = led*3 + {r:0,g:1,b:2}; k<0 means unused.
    function automatic logic [59:0] ev3(input int k0, input int v0, input int k1,
                                        input int v1, input int k2, input int v2);
        logic [59:0] r;
        r = 60'd0;
        if (k0 >= 0) r[k0*5 +: 5] = 5'(v0);
        if (k1 >= 0) r[k1*5 +: 5] = 5'(v1);
        if (k2 >= 0) r[k2*5 +: 5] = 5'(v2);
        return r;
    endfunction

    // Monitor: on a request, sample a window of outputs and compare with the queue head.
    initial begin
        exp_t        rec;
        int          acc [12];
        logic [59:0] got;
        forever begin
            @(posedge clk);
            if (mon_go) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL monitor: request with no expected entry");
                end else begin
                    rec = exp_q.pop_front();
                    for (int k = 0; k < 12; k++) acc[k] = 0;
                    for (int t = 0; t < rec.len; t++) begin
                        @(negedge clk);
                        for (int n = 0; n < 4; n++) begin
                            acc[n*3 + 0] += int'(rgb_leds[n].r);
                            acc[n*3 + 1] += int'(rgb_leds[n].g);
                            acc[n*3 + 2] += int'(rgb_leds[n].b);
                        end
                    end
                    got = 60'd0;
                    for (int k = 0; k < 12; k++) got[k*5 +: 5] = 5'(acc[k]);
                    if (rec.chk_cnt) begin
                        checks++;
                        if (got !== rec.cnt) begin
                            errors++;
                            $display("FAIL %s counts: got %h expected %h", rec.name, got, rec.cnt);
                        end
                    end
                    checks++;
                    if (green_leds !== rec.green) begin
                        errors++;
                        $display("FAIL %s green: got %b expected %b", rec.name, green_leds, rec.green);
                    end
                end
                done_cnt++;
            end
        end
    end

    task automatic measure(input string name, input int len, input bit chk,
                           input logic [59:0] cnt, input logic [3:0] green);
        exp_t rec;
        rec.name    = name;
        rec.len     = len;
        rec.chk_cnt = chk;
        rec.cnt     = cnt;
        rec.green   = green;
        exp_q.push_back(rec);
        issued++;
        mon_go = 1'b1;
        @(negedge clk);
        mon_go = 1'b0;
        for (int i = 0; i < 200 && done_cnt != issued; i++) @(negedge clk);
        if (done_cnt != issued) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: monitor done %0d expected %0d", name, done_cnt, issued);
        end
    endtask

    task automatic press(input logic [3:0] m);
        buttons = m;
        repeat (HOLD) @(negedge clk);
        buttons = 4'b0000;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic settle();
        repeat (40) @(negedge clk);
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        bit seen_on;
        rst_i    = 1'b1;
        buttons  = 4'b0000;
        switches = 4'b0000;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        measure("reset_now", 1, 1'b1, 60'd0, 4'b0001);
        switches = 4'b0001;
        repeat (8) @(negedge clk);
        measure("reset_dark", 16, 1'b1, 60'd0, 4'b0001);

        press(4'b0001); settle();
        measure("duty4", 16, 1'b1, ev3(0, 4, -1, 0, -1, 0), 4'b0001);
        repeat (4) press(4'b0001);
        settle();
        measure("sat_hi", 16, 1'b1, ev3(0, 15, -1, 0, -1, 0), 4'b0001);
        repeat (5) press(4'b0010);
        settle();
        measure("sat_lo", 16, 1'b1, 60'd0, 4'b0001);
        repeat (2) press(4'b0001);
        settle();
        measure("duty8", 16, 1'b1, ev3(0, 8, -1, 0, -1, 0), 4'b0001);

`ifdef RGB_PWM_DEBOUNCE_EN
        repeat (4) begin
            buttons = 4'b0001;
            repeat (3) @(negedge clk);
            buttons = 4'b0000;
            repeat (3) @(negedge clk);
        end
        settle();
        measure("glitch", 16, 1'b1, ev3(0, 8, -1, 0, -1, 0), 4'b0001);
`endif

        press(4'b0100); measure("sel1", 1, 1'b0, 60'd0, 4'b0010);
        press(4'b0100); measure("sel2", 1, 1'b0, 60'd0, 4'b0100);
        press(4'b0100); measure("sel3", 1, 1'b0, 60'd0, 4'b1000);
        press(4'b0100); measure("sel0", 1, 1'b0, 60'd0, 4'b0001);

        press(4'b1000); press(4'b0001); settle();
        measure("col_g", 16, 1'b1, ev3(0, 8, 1, 4, -1, 0), 4'b0001);
        press(4'b0011); settle();
        measure("inc_dec", 16, 1'b1, ev3(0, 8, 1, 4, -1, 0), 4'b0001);

        press(4'b0100); press(4'b0001);
        switches = 4'b0011;
        settle();
        measure("led1_g", 16, 1'b1, ev3(0, 8, 1, 4, 4, 4), 4'b0010);
        press(4'b0101); settle();
        measure("edit_old_sel", 16, 1'b1, ev3(0, 8, 1, 4, 4, 8), 4'b0100);

        switches = 4'b0010;
        repeat (3) @(negedge clk);
        measure("gate_off", 16, 1'b1, ev3(4, 8, -1, 0, -1, 0), 4'b0100);

        switches = 4'b0011;
        settle();
        seen_on = 1'b0;
        for (int i = 0; i < 40 && !seen_on; i++) begin
            @(negedge clk);
            seen_on = (rgb_leds[0].r === 1'b1);
        end
        checks++;
        if (!seen_on) begin
            errors++;
            $display("FAIL pre_reset_on: got led0.r never high expected high within 40 cycles");
        end
        rst_i = 1'b1;
        measure("reset_mid", 1, 1'b1, 60'd0, 4'b0001);
        rst_i = 1'b0;
        settle();
        measure("reset_clear", 16, 1'b1, 60'd0, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
